// File: rtl/pwm_capture_pkg.sv
// Shared constants for the PWM input-capture block: register map, field
// positions and the measurement state encoding exposed in STATUS.
package pwm_capture_pkg;

  localparam logic [2:0] REG_CTRL    = 3'd0;
  localparam logic [2:0] REG_STATUS  = 3'd1;
  localparam logic [2:0] REG_PERIOD  = 3'd2;
  localparam logic [2:0] REG_HIGH    = 3'd3;
  localparam logic [2:0] REG_TIMEOUT = 3'd4;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_CLEAR  = 2;

  localparam int STAT_DONE  = 0;
  localparam int STAT_OVF   = 1;
  localparam int STAT_STUCK = 2;
  localparam int STAT_LEVEL = 3;
  localparam int STAT_STATE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } state_e;

endpackage

// File: rtl/pwm_capture_sync.sv
// Two-flop synchronizer for the asynchronous PWM input followed by a
// one-cycle rise/fall edge detector on the synchronized level.
module pwm_capture_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pwm_i,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta, sync, prev;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= pwm_i;
      sync <= meta;
      prev <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~prev;
  assign fall  = ~sync & prev;

endmodule

// File: rtl/pwm_capture.sv
// PWM input capture: measures period and high time in clock cycles and
// exposes results through a valid/ready register port.
//   state | meaning
//   IDLE  | capture disabled, counters held at 0
//   ARM   | waiting for the first rising edge
//   HIGH  | counting the high phase of the current period
//   LOW   | counting the low phase; next rise latches the result
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int BITS = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic            we_i,
  input  logic [31:0]     addr_i,
  input  logic [BITS-1:0] wdata_i,
  output logic [BITS-1:0] rdata_o,
  input  logic            pwm_i,
  output logic            irq_o
);

  logic            level, rise, fall;
  logic            acc, wr, rd_en, wr_ctrl, wr_status, wr_timeout;
  logic [2:0]      reg_sel;
  logic            en_q, irq_en_q, done_q, ovf_q, stuck_q;
  logic            en_nx, clear;
  logic [BITS-1:0] per_cnt, hi_cnt, period_q, high_q, timeout_q, rd_val;
  logic            tmo_hit, per_max, hi_max, per_sat, hi_sat;
  logic            capture, timeout, cnt_zero, cnt_start, cnt_run, hi_run;
  logic            unused_addr;
  state_e          state_q, state_nx;

  pwm_capture_sync u_sync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .pwm_i (pwm_i),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  assign unused_addr = ^{addr_i[31:5], addr_i[1:0]};
  assign reg_sel     = addr_i[4:2];
  assign acc         = valid_i & ~ready_o;
  assign wr          = acc & we_i;
  assign rd_en       = acc & ~we_i;
  assign wr_ctrl     = wr && (reg_sel == REG_CTRL);
  assign wr_status   = wr && (reg_sel == REG_STATUS);
  assign wr_timeout  = wr && (reg_sel == REG_TIMEOUT);
  assign en_nx       = wr_ctrl ? wdata_i[CTRL_EN] : en_q;
  assign clear       = wr_ctrl & wdata_i[CTRL_CLEAR];

  assign tmo_hit = (timeout_q != '0) && (per_cnt == timeout_q);
  assign per_max = &per_cnt;
  assign hi_max  = &hi_cnt;
  assign per_sat = cnt_run & per_max;
  assign hi_sat  = hi_run & hi_max;
  assign irq_o   = done_q & irq_en_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_nx;
  end

  // Priority: clear, then disable, then enable, then timeout, then edges.
  always_comb begin
    state_nx  = state_q;
    capture   = 1'b0;
    timeout   = 1'b0;
    cnt_zero  = 1'b0;
    cnt_start = 1'b0;
    cnt_run   = 1'b0;
    hi_run    = 1'b0;
    if (clear) begin
      state_nx = en_nx ? ARM : IDLE;
      cnt_zero = 1'b1;
    end else if (!en_nx) begin
      state_nx = IDLE;
      cnt_zero = 1'b1;
    end else if (!en_q) begin
      state_nx = ARM;
      cnt_zero = 1'b1;
    end else begin
      case (state_q)
        IDLE: state_nx = ARM;
        ARM: begin
          if (rise) begin
            cnt_start = 1'b1;
            state_nx  = HIGH;
          end
        end
        HIGH: begin
          if (tmo_hit) begin
            timeout  = 1'b1;
            cnt_zero = 1'b1;
            state_nx = ARM;
          end else begin
            cnt_run = 1'b1;
            if (fall) state_nx = LOW;
            else      hi_run   = 1'b1;
          end
        end
        LOW: begin
          if (tmo_hit) begin
            timeout  = 1'b1;
            cnt_zero = 1'b1;
            state_nx = ARM;
          end else if (rise) begin
            capture   = 1'b1;
            cnt_start = 1'b1;
            state_nx  = HIGH;
          end else begin
            cnt_run = 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      per_cnt <= '0;
      hi_cnt  <= '0;
    end else if (cnt_zero) begin
      per_cnt <= '0;
      hi_cnt  <= '0;
    end else if (cnt_start) begin
      per_cnt <= BITS'(1);
      hi_cnt  <= BITS'(1);
    end else begin
      if (cnt_run && !per_max) per_cnt <= per_cnt + 1'b1;
      if (hi_run && !hi_max)   hi_cnt  <= hi_cnt + 1'b1;
    end
  end

  // Flag set conditions win over a coincident write-1-to-clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_q      <= 1'b0;
      irq_en_q  <= 1'b0;
      timeout_q <= '0;
      period_q  <= '0;
      high_q    <= '0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      stuck_q   <= 1'b0;
    end else begin
      en_q <= en_nx;
      if (wr_ctrl)    irq_en_q  <= wdata_i[CTRL_IRQ_EN];
      if (wr_timeout) timeout_q <= wdata_i;

      if (clear) begin
        period_q <= '0;
        high_q   <= '0;
      end else if (timeout) begin
        period_q <= '0;
        high_q   <= level ? timeout_q : '0;
      end else if (capture) begin
        period_q <= per_cnt;
        high_q   <= hi_cnt;
      end

      if (clear)                                done_q <= 1'b0;
      else if (capture || timeout)              done_q <= 1'b1;
      else if (wr_status && wdata_i[STAT_DONE]) done_q <= 1'b0;

      if (clear)                               ovf_q <= 1'b0;
      else if (per_sat || hi_sat)              ovf_q <= 1'b1;
      else if (wr_status && wdata_i[STAT_OVF]) ovf_q <= 1'b0;

      if (clear)                                 stuck_q <= 1'b0;
      else if (timeout)                          stuck_q <= 1'b1;
      else if (wr_status && wdata_i[STAT_STUCK]) stuck_q <= 1'b0;
    end
  end

  always_comb begin
    rd_val = '0;
    case (reg_sel)
      REG_CTRL: begin
        rd_val[CTRL_EN]     = en_q;
        rd_val[CTRL_IRQ_EN] = irq_en_q;
      end
      REG_STATUS: begin
        rd_val[STAT_DONE]         = done_q;
        rd_val[STAT_OVF]          = ovf_q;
        rd_val[STAT_STUCK]        = stuck_q;
        rd_val[STAT_LEVEL]        = level;
        rd_val[STAT_STATE +: 2]   = state_q;
      end
      REG_PERIOD:  rd_val = period_q;
      REG_HIGH:    rd_val = high_q;
      REG_TIMEOUT: rd_val = timeout_q;
      default:     rd_val = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ready_o <= 1'b0;
      rdata_o <= '0;
    end else begin
      ready_o <= acc;
      rdata_o <= rd_en ? rd_val : '0;
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed and randomized bench for pwm_capture: PWM phases are generated
// cycle by cycle and expected results come from phase lengths directly.
module tb_pwm_capture;

  localparam logic [31:0] A_CTRL = 32'h00, A_STATUS = 32'h04, A_PERIOD = 32'h08;
  localparam logic [31:0] A_HIGH = 32'h0C, A_TIMEOUT = 32'h10;

  logic        clk = 1'b0;
  logic        rst_n, valid_a, valid_b, we, pwm_a, pwm_b;
  logic [31:0] addr, wdata, rdata_a;
  logic [7:0]  rdata_b;
  logic        ready_a, ready_b, irq_a, irq_b;
  int          n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  pwm_capture #(.BITS(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_a), .ready_o(ready_a), .we_i(we),
    .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata_a), .pwm_i(pwm_a), .irq_o(irq_a)
  );

  pwm_capture #(.BITS(8)) dut8 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_b), .ready_o(ready_b), .we_i(we),
    .addr_i(addr), .wdata_i(wdata[7:0]), .rdata_o(rdata_b), .pwm_i(pwm_b), .irq_o(irq_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input bit sel, input bit w, input logic [31:0] a,
                     input logic [31:0] d, output logic [31:0] r);
    we = w; addr = a; wdata = d;
    if (sel) valid_b = 1'b1; else valid_a = 1'b1;
    tick();
    check("ack", sel ? ready_b : ready_a, 1);
    r = sel ? {24'h0, rdata_b} : rdata_a;
    valid_a = 1'b0; valid_b = 1'b0;
    tick();
    check("ack_drop", sel ? ready_b : ready_a, 0);
  endtask

  task automatic wr(input bit sel, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    bus(sel, 1'b1, a, d, r);
  endtask

  task automatic expect_reg(input bit sel, input logic [31:0] a, input logic [31:0] exp,
                            input string tag);
    logic [31:0] r;
    bus(sel, 1'b0, a, 32'h0, r);
    check(tag, r, exp);
  endtask

  task automatic set_pwm(input bit sel, input logic v);
    if (sel) pwm_b = v; else pwm_a = v;
  endtask

  task automatic pulse(input bit sel, input int h, input int l);
    set_pwm(sel, 1'b1);
    repeat (h) tick();
    set_pwm(sel, 1'b0);
    repeat (l) tick();
  endtask

  // Clean low gap, one full h/l period, then a held rise that captures it.
  task automatic measure(input bit sel, input int h, input int l);
    set_pwm(sel, 1'b0);
    repeat (3) tick();
    pulse(sel, h, l);
    set_pwm(sel, 1'b1);
    repeat (4) tick();
  endtask

  function automatic logic [31:0] sat(input int v, input int bits);
    longint mx;
    mx = (longint'(1) << bits) - 1;
    return (v > mx) ? 32'(mx) : 32'(v);
  endfunction

  function automatic logic [31:0] status(input bit done, input bit ovf, input bit stuck,
                                         input bit lvl, input int st);
    return 32'(done) | (32'(ovf) << 1) | (32'(stuck) << 2) | (32'(lvl) << 3) | (32'(st) << 4);
  endfunction

  initial begin
    int h, l, exp_p;
    rst_n = 1'b0; valid_a = 1'b0; valid_b = 1'b0; we = 1'b0;
    addr = '0; wdata = '0; pwm_a = 1'b0; pwm_b = 1'b0;
    repeat (3) tick();
    check("reset_ready", ready_a, 0);
    check("reset_rdata", rdata_a, 0);
    check("reset_irq", irq_a, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) expect_reg(0, 32'(i * 4), 0, "reset_reg");
    expect_reg(1, A_STATUS, 0, "reset_status8");
    wr(0, 32'h18, 32'hFFFF_FFFF);
    expect_reg(0, 32'h18, 0, "unmapped_read");

    wr(0, A_CTRL, 32'h3);
    expect_reg(0, A_CTRL, 32'h3, "ctrl_rb");
    expect_reg(0, A_STATUS, status(0, 0, 0, 0, 1), "armed");

    measure(0, 3, 7);
    check("irq_set", irq_a, 1);
    expect_reg(0, A_PERIOD, 10, "period_3_7");
    expect_reg(0, A_HIGH, 3, "high_3_7");
    expect_reg(0, A_STATUS, status(1, 0, 0, 1, 2), "done_3_7");
    wr(0, A_STATUS, 32'h1);
    expect_reg(0, A_STATUS, status(0, 0, 0, 1, 2), "done_w1c");
    check("irq_clr", irq_a, 0);

    measure(0, 1, 1);
    expect_reg(0, A_PERIOD, 2, "period_min");
    expect_reg(0, A_HIGH, 1, "high_min");

    exp_p = 0;
    for (int k = 0; k < 8; k++) begin
      h = int'($urandom_range(1, 25));
      l = int'($urandom_range(1, 25));
      measure(0, h, l);
      exp_p = h + l;
      expect_reg(0, A_PERIOD, 32'(exp_p), "period_rand");
      expect_reg(0, A_HIGH, 32'(h), "high_rand");
    end

    we = 1'b0; addr = A_PERIOD; valid_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("held_ready", ready_a, (i % 2 == 0) ? 1 : 0);
      check("held_rdata", rdata_a, (i % 2 == 0) ? 32'(exp_p) : 0);
    end
    valid_a = 1'b0;
    tick();

    wr(0, A_CTRL, 32'h7);
    wr(0, A_TIMEOUT, 32'd50);
    set_pwm(0, 1'b0);
    repeat (3) tick();
    set_pwm(0, 1'b1);
    repeat (60) tick();
    expect_reg(0, A_STATUS, status(1, 0, 1, 1, 1), "tmo_high_status");
    expect_reg(0, A_PERIOD, 0, "tmo_high_period");
    expect_reg(0, A_HIGH, 50, "tmo_high_high");
    check("tmo_irq", irq_a, 1);

    wr(0, A_STATUS, 32'h7);
    set_pwm(0, 1'b0);
    repeat (3) tick();
    set_pwm(0, 1'b1);
    repeat (3) tick();
    set_pwm(0, 1'b0);
    repeat (60) tick();
    expect_reg(0, A_STATUS, status(1, 0, 1, 0, 1), "tmo_low_status");
    expect_reg(0, A_HIGH, 0, "tmo_low_high");
    wr(0, A_TIMEOUT, 32'd0);
    wr(0, A_STATUS, 32'h7);

    measure(0, 4, 6);
    expect_reg(0, A_STATUS, status(1, 0, 0, 1, 2), "pre_disable");
    wr(0, A_CTRL, 32'h2);
    expect_reg(0, A_STATUS, status(1, 0, 0, 1, 0), "disabled_idle");
    expect_reg(0, A_PERIOD, 10, "disabled_period");
    expect_reg(0, A_HIGH, 4, "disabled_high");
    wr(0, A_CTRL, 32'h3);
    expect_reg(0, A_STATUS, status(1, 0, 0, 1, 1), "reenable_arm");

    set_pwm(0, 1'b0);
    repeat (3) tick();
    pulse(0, 3, 7);
    set_pwm(0, 1'b1);
    tick();
    tick();
    wr(0, A_CTRL, 32'h7);
    expect_reg(0, A_PERIOD, 0, "clear_cap_period");
    expect_reg(0, A_HIGH, 0, "clear_cap_high");
    expect_reg(0, A_STATUS, status(0, 0, 0, 1, 1), "clear_cap_status");

    set_pwm(0, 1'b0);
    repeat (3) tick();
    pulse(0, 5, 4);
    set_pwm(0, 1'b1);
    tick();
    tick();
    wr(0, A_STATUS, 32'h1);
    expect_reg(0, A_STATUS, status(1, 0, 0, 1, 2), "w1c_vs_capture");
    expect_reg(0, A_PERIOD, 9, "w1c_cap_period");
    expect_reg(0, A_HIGH, 5, "w1c_cap_high");

    wr(1, A_CTRL, 32'h1);
    measure(1, 100, 200);
    expect_reg(1, A_PERIOD, sat(300, 8), "sat_period");
    expect_reg(1, A_HIGH, sat(100, 8), "sat_high");
    expect_reg(1, A_STATUS, status(1, 1, 0, 1, 2), "sat_status");
    check("irq8_off", irq_b, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Input-capture companion to the PWM generator: measures period and high time of one external or looped-back PWM waveform in `clk_i` cycles. Exposes the results through the same valid/ready register port as the generator, so the top level can mount it in a free `wbs_adr_i[7:6]` slot and drive it from the same decoded `valid` and `wbs_dat_i`. Typical use is closed-loop checking of `cio_pwm` or measuring a PWM pad input.

## Interface
- `BITS`, 32, width of data bus and capture counters
- `clk_i`  in  1  single clock; all logic on rising edge
- `rst_ni`  in  1  asynchronous active-low reset
- `valid_i`  in  1  register access request, already qualified by cyc & stb & slot select
- `ready_o`  out  1  one-cycle access acknowledge
- `we_i`  in  1  1 = write, 0 = read
- `addr_i`  in  32  byte address; only `[4:2]` decoded
- `wdata_i`  in  BITS  write data
- `rdata_o`  out  BITS  read data, valid while `ready_o` high, else 0
- `pwm_i`  in  1  asynchronous PWM input to measure
- `irq_o`  out  1  level: `STATUS.done & CTRL.irq_en`

## Operation
- Registers (offset → field):
  - 0x00 CTRL: [0] en, [1] irq_en, [2] clear (write-1 pulse, reads 0)
  - 0x04 STATUS: [0] done (W1C), [1] ovf (W1C), [2] stuck (W1C), [3] level (RO, synced input), [5:4] state (RO)
  - 0x08 PERIOD (RO), 0x0C HIGH (RO), 0x10 TIMEOUT (RW, 0 = disabled)
  - Offsets 0x14–0x1C: reads return 0, writes ignored, still acked.
- Input path: 2-flop synchronizer, then edge detector comparing sync output with its previous value; yields `rise`/`fall` strobes.
- FSM states (STATUS.state encoding):
  - IDLE=0: en=0; counters held at 0.
  - ARM=1: wait for first `rise`; on `rise` set `per_cnt`=1, `hi_cnt`=1, go HIGH.
  - HIGH=2: `per_cnt`++, `hi_cnt`++; on `fall` go LOW.
  - LOW=3: `per_cnt`++; on `rise` latch PERIOD←`per_cnt`, HIGH←`hi_cnt`, set done, reload `per_cnt`=`hi_cnt`=1, go HIGH.
- PERIOD/HIGH update together on the same cycle, so a read never sees a mixed pair.
- Counters saturate at 2^BITS−1 and set ovf; measurement continues.
- Timeout: TIMEOUT≠0 and `per_cnt`==TIMEOUT in HIGH or LOW → PERIOD←0, HIGH←(level ? TIMEOUT : 0), set stuck and done, go ARM.
- Any transition of en to 0 goes to IDLE from any state. PERIOD/HIGH/flags keep their values.
- en 0→1 goes to ARM.
- clear: counters to 0, PERIOD/HIGH/done/ovf/stuck to 0, state ARM if en, else IDLE.
- Precedence within one cycle: clear > en=0 > timeout > rise/fall.
  - A capture coinciding with a STATUS W1C of done leaves done=1 (set wins).

## Timing
- Reset values: `ready_o`=0, `rdata_o`=0, `irq_o`=0, all registers 0, state IDLE.
- Access: `valid_i` high with `ready_o` low → `ready_o`=1 next cycle, for exactly one cycle.
  - Held `valid_i` is therefore acked every other cycle.
  - Write takes effect on the ack cycle. Read data is sampled at request and presented on the ack cycle.
- Input latency: `pwm_i` edge at cycle n → `rise`/`fall` at n+2 → PERIOD/HIGH/done/`irq_o` visible at n+3.
- First result arrives only at the second rising edge after arming. The measured period includes no synchronizer offset, since both edges see equal delay.
- Minimum measurable high or low phase: 1 cycle after sync. Glitches shorter than 1 cycle may be lost.

## Structure
- `pwm_capture_pkg`:
  - register offset localparams (CTRL, STATUS, PERIOD, HIGH, TIMEOUT)
  - CTRL/STATUS bit-index localparams
  - state localparams IDLE/ARM/HIGH/LOW
- One sub-module, `pwm_capture_sync`: 2-flop synchronizer plus edge detect; outputs `level`, `rise`, `fall`. Reset value 0.
- FSM, counters and register file stay in `pwm_capture`.

## Test plan
- Reset, then read all five offsets → all 0. `ready_o` one cycle after each `valid_i`.
- en=1; `pwm_i` 3 high / 7 low repeating → after second rise, PERIOD=10, HIGH=3, done=1.
  - With irq_en=1, `irq_o`=1. W1C done → 0.
- en=1, TIMEOUT=50, `pwm_i` held high after one rise → stuck=1, PERIOD=0, HIGH=50, state=ARM.
- BITS=8, period 300 cycles → ovf=1, PERIOD=255.
- Disable mid-period (state HIGH) → state IDLE, previous PERIOD/HIGH kept. Re-enable → ARM.
- clear on the same cycle as a capturing rise → PERIOD=HIGH=0, done=0.
  - Separately, a W1C of done on the capture cycle → done=1.
